// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 64 x 64 integer register file.
// Vectors are MSB-first: bit 0 is the most significant bit.
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int ZERO_REG   = 0;

  typedef logic [0:ADDR_WIDTH-1] reg_addr_t;
  typedef logic [0:DATA_WIDTH-1] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, register-0 override and, when
// REGFILE_WRITE_BYPASS_EN is defined, forwarding of the in-flight write.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic [0:ADDR_WIDTH-1] address,
  input  logic [0:DATA_WIDTH-1] regs [2**ADDR_WIDTH],
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [0:ADDR_WIDTH-1] wr_addr,
  input  logic [0:DATA_WIDTH-1] wr_data,
`endif
  output logic [0:DATA_WIDTH-1] data
);

  always_comb begin
    data = regs[address];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward only writes that will actually commit at the next edge.
    if (!rst && wr_en && (wr_addr != ADDR_WIDTH'(ZERO_REG)) && (wr_addr == address))
      data = wr_data;
`endif
    if (address == ADDR_WIDTH'(ZERO_REG))
      data = '0;
  end

endmodule

// File: rtl/register_file_2r1w.sv
// Integer register file: two combinational read ports, one synchronous write
// port, entry 0 reads as zero. Optional write-through: REGFILE_WRITE_BYPASS_EN.
module register_file_2r1w
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:ADDR_WIDTH-1] address1,
  input  logic [0:ADDR_WIDTH-1] address2,
  input  logic [0:ADDR_WIDTH-1] addressw,
  input  logic [0:DATA_WIDTH-1] writeData,
  input  logic                  writeEn,
  output logic [0:DATA_WIDTH-1] read1,
  output logic [0:DATA_WIDTH-1] read2
);
  import regfile_pkg::*;

  logic [0:DATA_WIDTH-1] regs [2**ADDR_WIDTH];

  // Reset wins over a coincident write; address 0 is never written.
  always_ff @(posedge clk) begin
    if (rst)
      regs <= '{default: '0};
    else if (writeEn && (addressw != ADDR_WIDTH'(ZERO_REG)))
      regs[addressw] <= writeData;
  end

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port1 (
    .address (address1),
    .regs    (regs),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst     (rst),
    .wr_en   (writeEn),
    .wr_addr (addressw),
    .wr_data (writeData),
`endif
    .data    (read1)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port2 (
    .address (address2),
    .regs    (regs),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst     (rst),
    .wr_en   (writeEn),
    .wr_addr (addressw),
    .wr_data (writeData),
`endif
    .data    (read2)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w; honours REGFILE_WRITE_BYPASS_EN.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:5]  address1, address2, addressw;
  logic [0:63] writeData;
  logic        writeEn;
  logic [0:63] read1, read2;

  logic [0:63] model [64];
  logic [0:63] exp_q [$];
  logic [0:63] exp_v;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_2r1w dut (
    .clk(clk), .rst(rst),
    .address1(address1), .address2(address2), .addressw(addressw),
    .writeData(writeData), .writeEn(writeEn),
    .read1(read1), .read2(read2)
  );

  function automatic logic [0:63] model_rd(input logic [0:5] a);
    return (a == 6'd0) ? 64'd0 : model[a];
  endfunction

  // Stimulus only: one write-port cycle, model updated at the committing edge.
  task automatic drive_write(input logic [0:5] a, input logic [0:63] d, input logic en);
    @(negedge clk);
    addressw = a; writeData = d; writeEn = en;
    @(posedge clk);
    if (rst) foreach (model[i]) model[i] = 64'd0;
    else if (en && a != 6'd0) model[a] = d;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 20; k++)
      drive_write(6'($urandom_range(1, 63)), {$urandom, $urandom}, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    foreach (model[i]) model[i] = 64'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
      address1 = 6'(i); address2 = 6'(63 - i);
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (read1 !== exp_v) begin bad++; $display("FAIL reset_r1 addr=%0d got=%h want=%h", i, read1, exp_v); end
      exp_v = exp_q.pop_front(); total++;
      if (read2 !== exp_v) begin bad++; $display("FAIL reset_r2 addr=%0d got=%h want=%h", 63 - i, read2, exp_v); end
    end
  endtask

  task automatic test_basic();
    drive_write(6'd1, 64'h1234567890ABCDEF, 1'b1);
    drive_write(6'd2, 64'hFEDCBA0987654321, 1'b1);
    exp_q.push_back(64'h1234567890ABCDEF);
    exp_q.push_back(64'hFEDCBA0987654321);
    address1 = 6'd1; address2 = 6'd2;
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL basic_r1 got=%h want=%h", read1, exp_v); end
    exp_v = exp_q.pop_front(); total++;
    if (read2 !== exp_v) begin bad++; $display("FAIL basic_r2 got=%h want=%h", read2, exp_v); end
    // Same address on both ports
    exp_q.push_back(64'hFEDCBA0987654321);
    exp_q.push_back(64'hFEDCBA0987654321);
    address1 = 6'd2; address2 = 6'd2;
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL same_addr_r1 got=%h want=%h", read1, exp_v); end
    exp_v = exp_q.pop_front(); total++;
    if (read2 !== exp_v) begin bad++; $display("FAIL same_addr_r2 got=%h want=%h", read2, exp_v); end
  endtask

  task automatic test_zero_reg();
    drive_write(6'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h1234567890ABCDEF);
    address1 = 6'd0; address2 = 6'd1;
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL zero_reg got=%h want=%h", read1, exp_v); end
    exp_v = exp_q.pop_front(); total++;
    if (read2 !== exp_v) begin bad++; $display("FAIL zero_reg_r1 got=%h want=%h", read2, exp_v); end
    exp_q.push_back(64'hFEDCBA0987654321);
    address1 = 6'd2;
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL zero_reg_r2 got=%h want=%h", read1, exp_v); end
  endtask

  task automatic test_write_disabled();
    for (int k = 0; k < 4; k++)
      drive_write(6'd3, 64'hDEADBEEF00000000, 1'b0);
    exp_q.push_back(64'd0);
    address1 = 6'd3; address2 = 6'd3;
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v || read2 !== exp_v) begin
      bad++; $display("FAIL wr_disabled got=%h/%h want=%h", read1, read2, exp_v);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    address1 = 6'd5; address2 = 6'd6;
    addressw = 6'd5; writeData = 64'hA5A5A5A5A5A5A5A5; writeEn = 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_q.push_back(64'hA5A5A5A5A5A5A5A5);
`else
    exp_q.push_back(model_rd(6'd5));
`endif
    exp_q.push_back(model_rd(6'd6));
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL rw_before_edge got=%h want=%h", read1, exp_v); end
    exp_v = exp_q.pop_front(); total++;
    if (read2 !== exp_v) begin bad++; $display("FAIL rw_other_port got=%h want=%h", read2, exp_v); end
    @(posedge clk);
    model[5] = 64'hA5A5A5A5A5A5A5A5;
    exp_q.push_back(64'hA5A5A5A5A5A5A5A5);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL rw_after_edge got=%h want=%h", read1, exp_v); end
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 64; i++)
      drive_write(6'(i), 64'h1000 + 64'(i), 1'b1);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back((i == 0) ? 64'd0 : 64'h1000 + 64'(i));
      exp_q.push_back((i == 63) ? 64'd0 : 64'h1000 + 64'(63 - i));
      address1 = 6'(i); address2 = 6'(63 - i);
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (read1 !== exp_v) begin bad++; $display("FAIL sweep_r1 addr=%0d got=%h want=%h", i, read1, exp_v); end
      exp_v = exp_q.pop_front(); total++;
      if (read2 !== exp_v) begin bad++; $display("FAIL sweep_r2 addr=%0d got=%h want=%h", 63 - i, read2, exp_v); end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; writeEn = 1'b1; addressw = 6'd7; writeData = 64'hCAFEF00DCAFEF00D;
    address1 = 6'd7; address2 = 6'd8;
`ifdef REGFILE_WRITE_BYPASS_EN
    // Bypass stays off while reset is asserted
    exp_q.push_back(model_rd(6'd7));
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL bypass_in_reset got=%h want=%h", read1, exp_v); end
`endif
    @(posedge clk);
    foreach (model[i]) model[i] = 64'd0;
    @(negedge clk);
    rst = 1'b0; writeEn = 1'b0;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (read1 !== exp_v) begin bad++; $display("FAIL rst_priority got=%h want=%h", read1, exp_v); end
    exp_v = exp_q.pop_front(); total++;
    if (read2 !== exp_v) begin bad++; $display("FAIL rst_clears_r2 got=%h want=%h", read2, exp_v); end
  endtask

  initial begin
    rst = 1'b1; writeEn = 1'b0;
    address1 = '0; address2 = '0; addressw = '0; writeData = '0;
    foreach (model[i]) model[i] = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_zero_reg();
    test_write_disabled();
    test_same_cycle();
    test_sweep();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
